instr_decode_stage: RTL and testbench

- Registered decode stage that sits directly upstream of the immediate extension unit.
- Accepts 32-bit instructions from fetch through a valid/ready handshake, splits each into its fields, and produces imm16 plus the U (zero-extend) select consumed by the extension unit.
- Contains a 2-entry skid buffer, so in_ready is a registered signal and back-pressure from execute never creates a combinational path to fetch.

---
 rtl/decode_pkg.sv | 54 +++++
 rtl/instr_field_decoder.sv | 46 ++++
 rtl/instr_decode_stage.sv | 111 +++++++++++
 tb/tb_instr_decode_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
// Illegal-opcode constants only exist when DECODE_ILLEGAL_TRAP_EN is defined.
package decode_pkg;

    localparam int IW_C   = 32;
    localparam int PCW_C  = 32;
    localparam int IMMW_C = 16;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;
    localparam int SHAMT_LSB = 6;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SLTU = 6'h2B;
`endif

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic [PCW_C-1:0]  pc;
        logic [5:0]        opcode;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [5:0]        funct;
        logic [IMMW_C-1:0] imm;
        logic              u;
        logic              illegal;
    } decoded_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational field split of one instruction into a decoded_t.
// The illegal-opcode table is built only with DECODE_ILLEGAL_TRAP_EN.
module instr_field_decoder
    import decode_pkg::*;
#(
    parameter int IW  = IW_C,
    parameter int PCW = PCW_C
) (
    input  logic [IW-1:0]  instr,
    input  logic [PCW-1:0] pc,
    output decoded_t       dec
);

    logic [5:0] opc;
    logic [5:0] fn;
    logic       unused_shamt;

    assign opc = instr[OPC_LSB +: 6];
    assign fn  = instr[FUNCT_LSB +: 6];
    assign unused_shamt = ^instr[SHAMT_LSB +: 5];

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.opcode  = opc;
        dec.rs      = instr[RS_LSB +: 5];
        dec.rt      = instr[RT_LSB +: 5];
        dec.rd      = instr[RD_LSB +: 5];
        dec.funct   = fn;
        dec.imm     = instr[IMM_LSB +: IMMW_C];
        // Logical immediates and LUI zero-extend; everything else sign-extends.
        dec.u       = opc inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
`ifdef DECODE_ILLEGAL_TRAP_EN
        unique case (1'b1)
            opc == OP_RTYPE:
                dec.illegal = !(fn inside {FN_SLL, FN_SRL, FN_SRA, FN_JR,
                                           [FN_ADD:FN_SLTU]});
            opc inside {[OP_J:OP_LUI], [OP_LB:OP_SW]}:
                dec.illegal = 1'b0;
            default:
                dec.illegal = 1'b1;
        endcase
`endif
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer ahead of execute.
// Define DECODE_ILLEGAL_TRAP_EN to drive out_illegal from the opcode table.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int IW   = 32,
    parameter int PCW  = 32,
    parameter int IMMW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    input  logic [PCW-1:0]  in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PCW-1:0]  out_pc,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [5:0]      out_funct,
    output logic [IMMW-1:0] out_imm,
    output logic            out_u,
    output logic            out_illegal
);

    decoded_t dec;
    decoded_t main_q, main_d;
    decoded_t skid_q, skid_d;
    state_e   state_q, state_d;
    logic     in_ready_q, in_ready_d;
    logic     out_valid_q, out_valid_d;
    logic     acc, drn;

    instr_field_decoder #(
        .IW  (IW),
        .PCW (PCW)
    ) u_dec (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    assign acc = in_valid && in_ready_q;
    assign drn = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (acc) state_d = ST_ONE;
            ST_ONE: begin
                if (acc && !drn)      state_d = ST_FULL;
                else if (!acc && drn) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drn) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // Flush leaves stale data in place; only the valid flags are cleared.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        if (!flush) begin
            unique case (state_q)
                ST_EMPTY: if (acc) main_d = dec;
                ST_ONE: begin
                    if (acc && drn) main_d = dec;
                    else if (acc)   skid_d = dec;
                end
                ST_FULL:  if (drn) main_d = skid_q;
                default:  ;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.opcode;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_rd      = main_q.rd;
    assign out_funct   = main_q.funct;
    assign out_imm     = main_q.imm;
    assign out_u       = main_q.u;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: queue model plus directed literal checks.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [5:0]  out_funct;
    logic [15:0] out_imm;
    logic        out_u;
    logic        out_illegal;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_rd      (out_rd),
        .out_funct   (out_funct),
        .out_imm     (out_imm),
        .out_u       (out_u),
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    bit   m_ready = 1'b0;
    bit   m_drain;
    bit   m_acc;
    int   n_chk = 0;
    int   n_err = 0;
    ent_t ce;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ref_illegal(input logic [31:0] ins);
        int op = int'(ins >> 26);
        int fn = int'(ins & 32'd63);
        if (op == 0)
            return !(fn == 0 || fn == 2 || fn == 3 || fn == 8 || (fn >= 32 && fn <= 43));
        return !((op >= 2 && op <= 15) || (op >= 32 && op <= 43));
    endfunction

    function automatic bit exp_illegal(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_TRAP_EN
        return ref_illegal(ins);
`else
        return (ins === 32'hx) ? 1'b1 : 1'b0;
`endif
    endfunction

    // Reference: FIFO of at most two entries, pop before push.
    always @(posedge clk) begin
        if (rst_n) begin
            m_drain = (mq.size() > 0) && out_ready;
            m_acc   = in_valid && m_ready;
            if (m_drain) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (m_acc) mq.push_back('{in_instr, in_pc});
            m_ready = (mq.size() < 2);
        end
    end

    always @(negedge rst_n) begin
        mq.delete();
        m_ready = 1'b0;
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, m_ready);
        if (mq.size() > 0) begin
            ce = mq[0];
            chk("out_pc", out_pc, ce.pc);
            chk("out_opcode", out_opcode, (ce.instr >> 26) & 32'h3F);
            chk("out_rs", out_rs, (ce.instr >> 21) & 32'h1F);
            chk("out_rt", out_rt, (ce.instr >> 16) & 32'h1F);
            chk("out_rd", out_rd, (ce.instr >> 11) & 32'h1F);
            chk("out_funct", out_funct, ce.instr & 32'h3F);
            chk("out_imm", out_imm, ce.instr & 32'hFFFF);
            chk("out_u", out_u, ((ce.instr >> 26) >= 12) && ((ce.instr >> 26) <= 15));
            chk("out_illegal", out_illegal, exp_illegal(ce.instr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    logic [5:0] ops [11] = '{6'h00, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                             6'h0F, 6'h20, 6'h2B, 6'h3F, 6'h1C};
    logic [31:0] rnd;

    initial begin
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        in_pc     = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_pc", out_pc, 0);
        chk("rst out_imm", out_imm, 0);
        chk("rst out_u", out_u, 0);
        #9 rst_n = 1'b1;
        step();
        chk("ready after release", in_ready, 1);

        offer(32'h3C01_1234, 32'h100);
        step();
        chk("lui valid", out_valid, 1);
        chk("lui opcode", out_opcode, 6'h0F);
        chk("lui rt", out_rt, 5'd1);
        chk("lui imm", out_imm, 16'h1234);
        chk("lui u", out_u, 1);

        offer(32'h2002_FFFF, 32'h104);
        step();
        chk("addi imm", out_imm, 16'hFFFF);
        chk("addi u", out_u, 0);
        chk("addi sext", out_u ? {16'h0, out_imm} : {{16{out_imm[15]}}, out_imm},
            32'hFFFF_FFFF);

        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        offer(32'h0000_0020, 32'h200);
        step();
        offer(32'h0000_0022, 32'h204);
        step();
        chk("bp ready low", in_ready, 0);
        offer(32'h0000_0024, 32'h208);
        step();
        chk("bp hold ready", in_ready, 0);
        chk("bp hold pc", out_pc, 32'h200);
        step();
        out_ready = 1'b1;
        step();
        chk("bp second", out_pc, 32'h204);
        step();
        chk("bp third", out_pc, 32'h208);
        in_valid = 1'b0;
        step();
        chk("bp drained", out_valid, 0);

        out_ready = 1'b0;
        offer(32'h3403_0001, 32'h300);
        step();
        offer(32'h3404_0002, 32'h304);
        step();
        chk("full ready", in_ready, 0);
        offer(32'h3405_0003, 32'h308);
        flush = 1'b1;
        step();
        chk("flush valid", out_valid, 0);
        chk("flush ready", in_ready, 1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("flush no emit", out_valid, 0);

        offer(32'hFC00_0000, 32'h400);
        step();
        in_valid = 1'b0;
        chk("illegal valid", out_valid, 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal 3F", out_illegal, 1);
`else
        chk("illegal tied", out_illegal, 0);
`endif

        offer(32'h2006_0042, 32'h500);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst valid", out_valid, 0);
        chk("midrst pc", out_pc, 0);
        chk("midrst imm", out_imm, 0);
        chk("midrst ready", in_ready, 0);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        chk("midrst ready back", in_ready, 1);
        offer(32'h2007_0043, 32'h600);
        step();
        in_valid = 1'b0;
        chk("midrst first valid", out_valid, 1);
        chk("midrst first pc", out_pc, 32'h600);

        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 1) == 1) rnd[31:26] = ops[$urandom_range(0, 10)];
            in_instr  = rnd;
            in_pc     = 32'h1000 + 32'(i) * 4;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
